// File: rtl/draw_queue_controller.sv
// rtl/draw_queue_controller.sv - queued drawing-command dispatcher with watchdog
//
// Purpose: buffers up to DEPTH command words from command_interface and hands
// them one at a time to the rasterizer with a single-cycle trigger pulse. It
// waits for r_done before the next dispatch. A watchdog bounds that wait. The
// block also provides abort/flush, sticky error flags and occupancy reporting.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   start        - enqueue request (one-cycle pulse)
//   cmd_in       - command word captured when start is accepted
//   r_done       - rasterizer completion pulse
//   abort        - flush the queue and cancel the in-flight command
//   err_clr      - clear the sticky error flags
//   trigger      - one-cycle dispatch pulse to the rasterizer
//   cmd_out      - command currently dispatched, held until the next dispatch
//   busy         - dispatcher active or queue not empty
//   full         - queue holds DEPTH entries
//   level        - queued entries, excluding the in-flight command
//   cmd_done     - one-cycle pulse when the in-flight command completes
//   timeout_err  - sticky, watchdog expired
//   overflow_err - sticky, start arrived while the queue was full
module draw_queue_controller #(
   parameter int CMD_W   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024,
   parameter int LVL_W   = $clog2(DEPTH + 1),
   parameter int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CMD_W-1:0] cmd_in,
   input  logic             r_done,
   input  logic             abort,
   input  logic             err_clr,
   output logic             trigger,
   output logic [CMD_W-1:0] cmd_out,
   output logic             busy,
   output logic             full,
   output logic [LVL_W-1:0] level,
   output logic             cmd_done,
   output logic             timeout_err,
   output logic             overflow_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRIG      = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [CMD_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_q;
   logic [TMR_W-1:0]  timer;

   logic              push;
   logic              pop;
   logic              wd_expire;
   logic              timeout_set;
   logic              overflow_set;
   logic              trigger_nxt;
   logic              cmd_done_nxt;
   logic [CMD_W-1:0]  cmd_out_nxt;
   logic [TMR_W-1:0]  timer_nxt;

   // full comes from the pre-edge level, so a pop in the same cycle does not
   // make room for a push.
   assign full  = (level_q == LVL_FULL);
   assign level = level_q;
   assign busy  = (state != IDLE) || (level_q != '0);

   assign push         = start && !full && !abort;
   assign overflow_set = start && full && !abort;
   assign wd_expire    = (TIMEOUT != 0) && (timer == TMR_LAST);

   // Queue storage has no reset; only the pointers define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= cmd_in;
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level_q      <= '0;
         timer        <= '0;
         trigger      <= 1'b0;
         cmd_done     <= 1'b0;
         cmd_out      <= '0;
         timeout_err  <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         trigger  <= trigger_nxt;
         cmd_done <= cmd_done_nxt;
         cmd_out  <= cmd_out_nxt;
         timer    <= timer_nxt;

         if (abort) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
               2'b10:   level_q <= level_q + 1'b1;
               2'b01:   level_q <= level_q - 1'b1;
               default: level_q <= level_q;
            endcase
         end

         // A set event in the same cycle as err_clr keeps the flag set.
         timeout_err  <= timeout_set  || (timeout_err  && !err_clr);
         overflow_err <= overflow_set || (overflow_err && !err_clr);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      if (level_q != '0) state_nxt = TRIG;
            TRIG:      state_nxt = WAIT_DONE;
            WAIT_DONE: if (r_done || wd_expire) state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Output / datapath next values.
   always_comb begin
      pop          = 1'b0;
      trigger_nxt  = 1'b0;
      cmd_done_nxt = 1'b0;
      timeout_set  = 1'b0;
      cmd_out_nxt  = cmd_out;
      timer_nxt    = timer;
      if (abort) begin
         timer_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (level_q != '0) begin
                  pop         = 1'b1;
                  trigger_nxt = 1'b1;
                  cmd_out_nxt = mem[rd_ptr];
               end
            end
            TRIG: begin
               // r_done is deliberately ignored here; the watchdog starts fresh.
               timer_nxt = '0;
            end
            WAIT_DONE: begin
               // r_done takes precedence over a simultaneous watchdog expiry.
               if (r_done) begin
                  cmd_done_nxt = 1'b1;
               end else if (wd_expire) begin
                  timeout_set = 1'b1;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            default: begin
               trigger_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_queue_controller.sv
// tb/tb_draw_queue_controller.sv - self-checking bench for draw_queue_controller
module tb_draw_queue_controller;

   localparam int CMD_W   = 16;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int LVL_W   = $clog2(DEPTH + 1);

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             start   = 1'b0;
   logic [CMD_W-1:0] cmd_in  = '0;
   logic             r_done  = 1'b0;
   logic             abort   = 1'b0;
   logic             err_clr = 1'b0;
   logic             trigger;
   logic [CMD_W-1:0] cmd_out;
   logic             busy;
   logic             full;
   logic [LVL_W-1:0] level;
   logic             cmd_done;
   logic             timeout_err;
   logic             overflow_err;

   draw_queue_controller #(
      .CMD_W   (CMD_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cmd_in       (cmd_in),
      .r_done       (r_done),
      .abort        (abort),
      .err_clr      (err_clr),
      .trigger      (trigger),
      .cmd_out      (cmd_out),
      .busy         (busy),
      .full         (full),
      .level        (level),
      .cmd_done     (cmd_done),
      .timeout_err  (timeout_err),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a plain queue of pending commands plus the age of the
   // in-flight command (-1 none, 0 on its trigger cycle, k = k-th wait cycle).
   logic [CMD_W-1:0] m_q[$];
   int               m_age;
   logic             m_trig;
   logic             m_done;
   logic             m_terr;
   logic             m_oerr;
   logic [CMD_W-1:0] m_cmd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_age  = -1;
      m_trig = 1'b0;
      m_done = 1'b0;
      m_terr = 1'b0;
      m_oerr = 1'b0;
      m_cmd  = '0;
   endtask

   task automatic model_step();
      bit was_full;
      bit tset;
      bit oset;
      was_full = (m_q.size() == DEPTH);
      tset   = 1'b0;
      oset   = 1'b0;
      m_trig = 1'b0;
      m_done = 1'b0;
      if (abort) begin
         m_q.delete();
         m_age = -1;
      end else begin
         oset = start && was_full;
         if (m_age < 0) begin
            if (m_q.size() > 0) begin
               m_cmd  = m_q.pop_front();
               m_trig = 1'b1;
               m_age  = 0;
            end
         end else if (m_age == 0) begin
            m_age = 1;
         end else if (r_done) begin
            m_done = 1'b1;
            m_age  = -1;
         end else if (m_age == TIMEOUT) begin
            tset  = 1'b1;
            m_age = -1;
         end else begin
            m_age++;
         end
         if (start && !was_full) m_q.push_back(cmd_in);
      end
      m_terr = tset || (m_terr && !err_clr);
      m_oerr = oset || (m_oerr && !err_clr);
   endtask

   task automatic check_outputs();
      chk("trigger",      32'(trigger),      32'(m_trig));
      chk("cmd_out",      32'(cmd_out),      32'(m_cmd));
      chk("cmd_done",     32'(cmd_done),     32'(m_done));
      chk("busy",         32'(busy),         32'((m_age >= 0) || (m_q.size() != 0)));
      chk("full",         32'(full),         32'(m_q.size() == DEPTH));
      chk("level",        32'(level),        32'(m_q.size()));
      chk("timeout_err",  32'(timeout_err),  32'(m_terr));
      chk("overflow_err", 32'(overflow_err), 32'(m_oerr));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      check_outputs();
   endtask

   task automatic cyc(input bit s, input logic [CMD_W-1:0] c, input bit rd,
                      input bit ab, input bit ec);
      start   = s;
      cmd_in  = c;
      r_done  = rd;
      abort   = ab;
      err_clr = ec;
      tick();
      start   = 1'b0;
      r_done  = 1'b0;
      abort   = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      model_reset();

      // Reset state
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: single command latency and completion
      cyc(1, 16'h00A5, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      chk("t1_trigger", 32'(trigger), 32'd1);
      chk("t1_cmd_out", 32'(cmd_out), 32'h00A5);
      cyc(0, '0, 0, 0, 0);
      chk("t1_trigger_one_cycle", 32'(trigger), 32'd0);
      cyc(0, '0, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      chk("t1_busy_waiting", 32'(busy), 32'd1);
      cyc(0, '0, 1, 0, 0);
      chk("t1_cmd_done", 32'(cmd_done), 32'd1);
      chk("t1_busy_after", 32'(busy), 32'd0);
      cyc(0, '0, 0, 0, 0);

      // 2: fill queue behind an in-flight command, then overflow, then drain
      for (int i = 1; i <= 6; i++) cyc(1, 16'(i), 0, 0, 0);
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_overflow", 32'(overflow_err), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, '0, 0, 0, 0);
         cyc(0, '0, 1, 0, 0);
         cyc(0, '0, 0, 0, 0);
      end
      chk("t2_last_cmd", 32'(cmd_out), 32'd5);
      cyc(0, '0, 0, 0, 1);
      chk("t2_ovf_cleared", 32'(overflow_err), 32'd0);

      // 3: watchdog expiry, then clear
      cyc(1, 16'h0033, 0, 0, 0);
      for (int i = 0; i < 12; i++) cyc(0, '0, 0, 0, 0);
      chk("t3_timeout", 32'(timeout_err), 32'd1);
      chk("t3_idle", 32'(busy), 32'd0);
      cyc(0, '0, 0, 0, 1);
      chk("t3_cleared", 32'(timeout_err), 32'd0);

      // 4: r_done on the final watchdog cycle wins
      cyc(1, 16'h0044, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         if (m_age == TIMEOUT) begin
            cyc(0, '0, 1, 0, 0);
            chk("t4_cmd_done", 32'(cmd_done), 32'd1);
            chk("t4_no_timeout", 32'(timeout_err), 32'd0);
            break;
         end
         cyc(0, '0, 0, 0, 0);
      end
      cyc(0, '0, 0, 0, 0);

      // 5: abort with start while busy
      for (int i = 0; i < 4; i++) cyc(1, 16'(16'h50 + i), 0, 0, 0);
      cyc(1, 16'h005F, 0, 1, 0);
      chk("t5_level", 32'(level), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_no_ovf", 32'(overflow_err), 32'd0);
      cyc(0, '0, 1, 0, 0);
      chk("t5_rdone_ignored", 32'(cmd_done), 32'd0);
      cyc(0, '0, 0, 0, 0);

      // 6: asynchronous reset mid-wait with two queued
      for (int i = 0; i < 3; i++) cyc(1, 16'(16'h60 + i), 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      tick();
      rst_n = 1'b1;
      cyc(1, 16'h0BEE, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      chk("t6_trigger", 32'(trigger), 32'd1);
      chk("t6_cmd_out", 32'(cmd_out), 32'h0BEE);
      cyc(0, '0, 0, 0, 0);
      cyc(0, '0, 1, 0, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cyc(1'($urandom_range(0, 1)), 16'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 19) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
